// File: rtl/memory_arbiter_pkg.sv
// Shared types and encodings for the two-master memory arbiter.
package memory_arbiter_pkg;

  // Access sequencing: sample/arbitrate, wait for memory, report completion.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  // Bus transfer type driven on mem_trans.
  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  // Access size encodings on mN_size / mem_size.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // A held (locked) grant continues a burst; anything else starts a new one.
  function automatic logic [1:0] grant_trans(input logic held);
    return held ? TRANS_SEQ : TRANS_NONSEQ;
  endfunction

endpackage

// File: rtl/memory_arbiter_arb_pick.sv
// Combinational two-way picker: a lone requester wins; on a tie the hold
// owner wins when its hold is valid, otherwise the master not granted last.
module arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic hold_owner,
  input  logic hold_valid,
  output logic valid,
  output logic winner
);

  // Resolve the winner from the two request levels.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = hold_valid ? hold_owner : ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-master arbiter in front of the single memory_controller port.
// Registers the winning request onto the memory bus, waits for mem_ready,
// and returns rdata/abort to the owner with a one-cycle done pulse.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_write,
  input  logic [1:0]        m0_size,
  input  logic [3:0]        m0_prot,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_abort,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_write,
  input  logic [1:0]        m1_size,
  input  logic [3:0]        m1_prot,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_prot,
  output logic [1:0]        mem_trans,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_abort,
  input  logic              mem_ready
);

  localparam int              CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  state_t              state_reg, state_next;
  logic                last_grant_reg, last_grant_next;
  logic                prev_lock_reg, prev_lock_next;
  logic                prev_abort_reg, prev_abort_next;
  logic [CNT_W-1:0]    lock_cnt_reg, lock_cnt_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                write_reg, write_next;
  logic [1:0]          size_reg, size_next;
  logic [3:0]          prot_reg, prot_next;
  logic [1:0]          trans_reg, trans_next;
  logic [1:0]          gnt_reg, gnt_next;
  logic [1:0]          done_reg, done_next;

  logic                own_req, other_req;
  logic                hold_valid, held;
  logic                pick_valid, pick_winner;
  logic [CNT_W-1:0]    lock_cnt_inc;

  // The previous owner may keep the bus while its lock stands; the count
  // bound only applies while the other master is actually waiting.
  always_comb begin
    own_req      = last_grant_reg ? m1_req : m0_req;
    other_req    = last_grant_reg ? m0_req : m1_req;
    hold_valid   = prev_lock_reg && !prev_abort_reg && own_req &&
                   ((lock_cnt_reg < LOCK_MAX) || !other_req);
    held         = pick_valid && hold_valid && (pick_winner == last_grant_reg);
    lock_cnt_inc = (lock_cnt_reg == LOCK_MAX) ? LOCK_MAX : lock_cnt_reg + CNT_W'(1);
  end

  arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_grant (last_grant_reg),
    .hold_owner (last_grant_reg),
    .hold_valid (hold_valid),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Next-state and bus/handshake register values.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    prev_lock_next  = prev_lock_reg;
    prev_abort_next = prev_abort_reg;
    lock_cnt_next   = lock_cnt_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    write_next      = write_reg;
    size_next       = size_reg;
    prot_next       = prot_reg;
    trans_next      = trans_reg;
    gnt_next        = gnt_reg;
    done_next       = done_reg;
    case (state_reg)
      IDLE: begin
        done_next = 2'b00;
        if (pick_valid) begin
          state_next      = ACCESS;
          last_grant_next = pick_winner;
          prev_lock_next  = pick_winner ? m1_lock : m0_lock;
          lock_cnt_next   = held ? lock_cnt_inc : '0;
          addr_next       = pick_winner ? m1_addr  : m0_addr;
          wdata_next      = pick_winner ? m1_wdata : m0_wdata;
          write_next      = pick_winner ? m1_write : m0_write;
          size_next       = pick_winner ? m1_size  : m0_size;
          prot_next       = pick_winner ? m1_prot  : m0_prot;
          trans_next      = grant_trans(held);
          gnt_next        = pick_winner ? 2'b10 : 2'b01;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_next                = COMPLETE;
          done_next[last_grant_reg] = 1'b1;
          prev_abort_next           = mem_abort;
          trans_next                = TRANS_IDLE;
        end
      end
      COMPLETE: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
        done_next  = 2'b00;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, arbitration history and memory bus registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      prev_lock_reg  <= 1'b0;
      prev_abort_reg <= 1'b0;
      lock_cnt_reg   <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      write_reg      <= 1'b0;
      size_reg       <= 2'd0;
      prot_reg       <= 4'd0;
      trans_reg      <= TRANS_IDLE;
      gnt_reg        <= 2'b00;
      done_reg       <= 2'b00;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      prev_lock_reg  <= prev_lock_next;
      prev_abort_reg <= prev_abort_next;
      lock_cnt_reg   <= lock_cnt_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      write_reg      <= write_next;
      size_reg       <= size_next;
      prot_reg       <= prot_next;
      trans_reg      <= trans_next;
      gnt_reg        <= gnt_next;
      done_reg       <= done_next;
    end
  end

  // Per-master response capture; rdata/abort hold until that master's next completion.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic [DATA_W-1:0] rdata_reg;
    logic              abort_reg;

    // Latch the memory response when this master's access completes.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_reg <= '0;
        abort_reg <= 1'b0;
      end else if (state_reg == ACCESS && mem_ready && last_grant_reg == 1'(gi)) begin
        rdata_reg <= mem_rdata;
        abort_reg <= mem_abort;
      end
    end
  end

  assign m0_gnt    = gnt_reg[0];
  assign m1_gnt    = gnt_reg[1];
  assign m0_done   = done_reg[0];
  assign m1_done   = done_reg[1];
  assign m0_rdata  = g_resp[0].rdata_reg;
  assign m1_rdata  = g_resp[1].rdata_reg;
  assign m0_abort  = g_resp[0].abort_reg;
  assign m1_abort  = g_resp[1].abort_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_write = write_reg;
  assign mem_size  = size_reg;
  assign mem_prot  = prot_reg;
  assign mem_trans = trans_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_memory_arbiter;

  localparam int MAXL = 4;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_write, m1_req, m1_lock, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_prot, m1_prot;
  logic        m0_gnt, m0_done, m0_abort, m1_gnt, m1_done, m1_abort;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_abort, mem_ready;
  logic [1:0]  mem_size, mem_trans;
  logic [3:0]  mem_prot;

  int n_cmp = 0;
  int n_err = 0;

  // Observations collected by serve()
  int          obs_who, obs_lat, obs_glat;
  logic [1:0]  obs_trans, obs_trans_done, obs_size;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_prot;
  logic        obs_write, obs_stable, obs_both, obs_early;
  logic        obs_done, obs_other_done, obs_abort, obs_gnt_done;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_write(m0_write), .m0_size(m0_size), .m0_prot(m0_prot),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_abort(m0_abort),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_write(m1_write), .m1_size(m1_size), .m1_prot(m1_prot),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_abort(m1_abort),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_size(mem_size), .mem_prot(mem_prot), .mem_trans(mem_trans),
    .mem_rdata(mem_rdata), .mem_abort(mem_abort), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0; m0_write = 0; m0_size = 0; m0_prot = 0;
    m1_req = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0; m1_write = 0; m1_size = 0; m1_prot = 0;
    mem_rdata = 0; mem_abort = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Plays the memory side of one access: waits for a grant, holds mem_ready low
  // for 'waits' ACCESS cycles, then returns rd/ab and records what was seen.
  task automatic serve(input int waits, input logic [31:0] rd, input logic ab);
    int n;
    int guard;
    obs_lat = 0; obs_stable = 1; obs_early = 0;
    mem_ready = 0;
    guard = 0;
    do begin
      tick(); obs_lat++; guard++;
    end while (!((m0_gnt || m1_gnt) && mem_trans != 2'd0) && guard < 20);
    n_cmp++;
    if (!((m0_gnt || m1_gnt) && mem_trans != 2'd0)) begin
      n_err++;
      $display("FAIL grant_timeout got no grant within %0d cycles, required a grant", guard);
      obs_who = -1; obs_done = 0; obs_trans = 2'd0;
      return;
    end
    obs_glat = obs_lat;
    obs_who = m1_gnt ? 1 : 0;
    obs_both = m0_gnt && m1_gnt;
    obs_trans = mem_trans; obs_addr = mem_addr; obs_wdata = mem_wdata;
    obs_write = mem_write; obs_size = mem_size; obs_prot = mem_prot;
    mem_rdata = rd; mem_abort = ab;
    n = waits;
    mem_ready = (n == 0);
    while (n > 0) begin
      tick(); obs_lat++;
      if (mem_addr !== obs_addr || mem_wdata !== obs_wdata || mem_trans !== obs_trans) obs_stable = 0;
      if (m0_done || m1_done) obs_early = 1;
      n--;
      mem_ready = (n == 0);
    end
    tick(); obs_lat++;
    mem_ready = 0; mem_abort = 0;
    obs_done       = obs_who ? m1_done  : m0_done;
    obs_other_done = obs_who ? m0_done  : m1_done;
    obs_rdata      = obs_who ? m1_rdata : m0_rdata;
    obs_abort      = obs_who ? m1_abort : m0_abort;
    obs_gnt_done   = obs_who ? m1_gnt   : m0_gnt;
    obs_trans_done = mem_trans;
  endtask

  task automatic test_reset();
    clear_inputs();
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF; mem_abort = 1;
    reset = 1;
    tick(); tick();
    reset = 0;
    mem_ready = 0; mem_abort = 0;
    n_cmp++;
    if ({m0_gnt, m0_done, m0_abort, m0_rdata, m1_gnt, m1_done, m1_abort, m1_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_master got gnt=%b%b done=%b%b abort=%b%b rdata=%h/%h required all 0",
               m0_gnt, m1_gnt, m0_done, m1_done, m0_abort, m1_abort, m0_rdata, m1_rdata);
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_write, mem_size, mem_prot, mem_trans} !== '0) begin
      n_err++;
      $display("FAIL reset_bus got addr=%h wdata=%h write=%b size=%0d prot=%h trans=%0d required all 0",
               mem_addr, mem_wdata, mem_write, mem_size, mem_prot, mem_trans);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h100; m0_write = 0; m0_size = 2'd2; m0_prot = 4'h3;
    serve(0, 32'hDEADBEEF, 0);
    m0_req = 0;
    $display("txn single_read: m%0d addr=%h trans=%0d lat=%0d", obs_who, obs_addr, obs_trans, obs_lat);
    n_cmp++; if (obs_who !== 0) begin n_err++; $display("FAIL single_who got=%0d required=0", obs_who); end
    n_cmp++; if (obs_glat !== 1 || obs_trans !== 2'd2) begin n_err++; $display("FAIL single_trans got glat=%0d trans=%0d required glat=1 trans=2", obs_glat, obs_trans); end
    n_cmp++; if (obs_addr !== 32'h100 || obs_size !== 2'd2 || obs_prot !== 4'h3) begin n_err++; $display("FAIL single_bus got addr=%h size=%0d prot=%h required 100/2/3", obs_addr, obs_size, obs_prot); end
    n_cmp++; if (obs_lat !== 2 || obs_done !== 1'b1 || obs_gnt_done !== 1'b1) begin n_err++; $display("FAIL single_done got lat=%0d done=%b gnt=%b required lat=2 done=1 gnt=1", obs_lat, obs_done, obs_gnt_done); end
    n_cmp++; if (obs_rdata !== 32'hDEADBEEF || obs_trans_done !== 2'd0) begin n_err++; $display("FAIL single_rdata got rdata=%h trans=%0d required DEADBEEF/0", obs_rdata, obs_trans_done); end
    tick();
    n_cmp++; if (m0_done !== 1'b0 || m0_gnt !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_after got done=%b gnt=%b rdata=%h required 0/0/DEADBEEF", m0_done, m0_gnt, m0_rdata); end
  endtask

  task automatic test_wait_states();
    do_reset();
    m1_req = 1; m1_addr = 32'h200; m1_wdata = 32'h55; m1_write = 1; m1_size = 2'd0;
    serve(3, 32'h1234_5678, 0);
    m1_req = 0;
    $display("txn wait_states: m%0d addr=%h wdata=%h lat=%0d", obs_who, obs_addr, obs_wdata, obs_lat);
    n_cmp++; if (obs_who !== 1 || obs_write !== 1'b1) begin n_err++; $display("FAIL wait_who got who=%0d write=%b required 1/1", obs_who, obs_write); end
    n_cmp++; if (obs_addr !== 32'h200 || obs_wdata !== 32'h55 || obs_stable !== 1'b1) begin n_err++; $display("FAIL wait_bus got addr=%h wdata=%h stable=%b required 200/55/1", obs_addr, obs_wdata, obs_stable); end
    n_cmp++; if (obs_lat !== 5 || obs_done !== 1'b1 || obs_early !== 1'b0) begin n_err++; $display("FAIL wait_done got lat=%0d done=%b early=%b required 5/1/0", obs_lat, obs_done, obs_early); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_req = 1; m0_addr = 32'hA0; m1_req = 1; m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      serve($urandom_range(0, 2), $urandom, 0);
      $display("txn round_robin %0d: m%0d trans=%0d", i, obs_who, obs_trans);
      n_cmp++; if (obs_who !== (i % 2) || obs_both !== 1'b0) begin n_err++; $display("FAIL rr_grant_%0d got who=%0d both=%b required who=%0d both=0", i, obs_who, obs_both, i % 2); end
      n_cmp++; if (obs_trans !== 2'd2 || obs_addr !== ((i % 2) ? 32'hB0 : 32'hA0)) begin n_err++; $display("FAIL rr_bus_%0d got trans=%0d addr=%h required trans=2", i, obs_trans, obs_addr); end
    end
    m0_req = 0; m1_req = 0;
  endtask

  task automatic test_lock_bound();
    int exp_who;
    int exp_tr;
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1; m1_lock = 0;
    for (int i = 0; i < 6; i++) begin
      exp_who = (i < MAXL + 1) ? 0 : 1;
      exp_tr  = (i == 0 || i == MAXL + 1) ? 2 : 3;
      serve(0, $urandom, 0);
      $display("txn lock_bound %0d: m%0d trans=%0d", i, obs_who, obs_trans);
      n_cmp++; if (obs_who !== exp_who || obs_trans !== 2'(exp_tr)) begin n_err++; $display("FAIL lock_%0d got who=%0d trans=%0d required who=%0d trans=%0d", i, obs_who, obs_trans, exp_who, exp_tr); end
    end
    m0_req = 0; m0_lock = 0; m1_req = 0;
  endtask

  task automatic test_abort();
    do_reset();
    m0_req = 1; m0_lock = 1; m1_req = 1;
    serve(1, 32'hBAD0_0000, 1);
    $display("txn abort: m%0d abort=%b done=%b", obs_who, obs_abort, obs_done);
    n_cmp++; if (obs_who !== 0 || obs_abort !== 1'b1 || obs_done !== 1'b1) begin n_err++; $display("FAIL abort_flag got who=%0d abort=%b done=%b required 0/1/1", obs_who, obs_abort, obs_done); end
    serve(0, 32'h0, 0);
    $display("txn abort_next: m%0d trans=%0d", obs_who, obs_trans);
    n_cmp++; if (obs_who !== 1 || obs_trans !== 2'd2) begin n_err++; $display("FAIL abort_next got who=%0d trans=%0d required 1/2", obs_who, obs_trans); end
    m0_req = 0; m0_lock = 0; m1_req = 0;
  endtask

  task automatic test_reset_mid_access();
    logic saw_done;
    int   guard;
    do_reset();
    m0_req = 1; m0_addr = 32'h300; m0_wdata = 32'h77; m0_write = 1;
    serve(0, 32'hA5A5_A5A5, 0);
    // Leave m0_req high so a second access starts, then stall it.
    saw_done = 0; guard = 0;
    mem_ready = 0;
    do begin tick(); guard++; end while (!(m0_gnt && mem_trans != 2'd0) && guard < 10);
    tick(); if (m0_done || m1_done) saw_done = 1;
    tick(); if (m0_done || m1_done) saw_done = 1;
    reset = 1;
    mem_ready = 1;
    tick(); if (m0_done || m1_done) saw_done = 1;
    $display("txn reset_mid: state=%0d gnt=%b%b", dut.state_reg, m0_gnt, m1_gnt);
    n_cmp++; if (saw_done !== 1'b0 || guard >= 10) begin n_err++; $display("FAIL rstmid_done got done_seen=%b guard=%0d required no done", saw_done, guard); end
    n_cmp++; if ({m0_gnt, m0_done, m0_abort, m0_rdata, m1_gnt, m1_done, m1_abort, m1_rdata} !== '0) begin n_err++; $display("FAIL rstmid_master got gnt=%b done=%b rdata=%h required all 0", m0_gnt, m0_done, m0_rdata); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_write, mem_size, mem_prot, mem_trans} !== '0) begin n_err++; $display("FAIL rstmid_bus got addr=%h wdata=%h trans=%0d required all 0", mem_addr, mem_wdata, mem_trans); end
    reset = 0; mem_ready = 0;
    m0_req = 1; m0_write = 0; m1_req = 1;
    serve(0, 32'h1, 0);
    n_cmp++; if (obs_who !== 0 || obs_done !== 1'b1) begin n_err++; $display("FAIL rstmid_tie got who=%0d done=%b required 0/1", obs_who, obs_done); end
    m0_req = 0; m1_req = 0;
  endtask

  // Random requests checked against a rule-level model of the arbiter history.
  task automatic test_random();
    int m_last, m_cnt, exp_who, waits;
    bit m_lock, m_abort, r0, r1, l0, l1, ab, can_hold, exp_held, own_r, oth_r;
    logic [31:0] rd, exp_addr, exp_wdata;
    logic exp_write;
    logic [1:0] exp_size;
    logic [3:0] exp_prot;
    do_reset();
    m_last = 1; m_cnt = 0; m_lock = 0; m_abort = 0;
    for (int it = 0; it < 40; it++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) begin if ($urandom_range(0, 1) == 1) r0 = 1; else r1 = 1; end
      l0 = ($urandom_range(0, 3) != 0); l1 = ($urandom_range(0, 2) == 0);
      m0_req = r0; m0_lock = l0; m0_addr = $urandom; m0_wdata = $urandom; m0_write = 1'($urandom_range(0, 1));
      m0_size = 2'($urandom_range(0, 2)); m0_prot = 4'($urandom_range(0, 15));
      m1_req = r1; m1_lock = l1; m1_addr = $urandom; m1_wdata = $urandom; m1_write = 1'($urandom_range(0, 1));
      m1_size = 2'($urandom_range(0, 2)); m1_prot = 4'($urandom_range(0, 15));
      waits = $urandom_range(0, 3); ab = ($urandom_range(0, 7) == 0); rd = $urandom;
      own_r = (m_last == 1) ? r1 : r0;
      oth_r = (m_last == 1) ? r0 : r1;
      can_hold = m_lock && !m_abort && own_r && (m_cnt < MAXL || !oth_r);
      if (r0 && r1) exp_who = can_hold ? m_last : 1 - m_last;
      else exp_who = r1 ? 1 : 0;
      exp_held = can_hold && (exp_who == m_last);
      exp_addr  = exp_who ? m1_addr  : m0_addr;
      exp_wdata = exp_who ? m1_wdata : m0_wdata;
      exp_write = exp_who ? m1_write : m0_write;
      exp_size  = exp_who ? m1_size  : m0_size;
      exp_prot  = exp_who ? m1_prot  : m0_prot;
      serve(waits, rd, ab);
      $display("txn random %0d: req=%b%b m%0d trans=%0d addr=%h waits=%0d abort=%b",
               it, r1, r0, obs_who, obs_trans, obs_addr, waits, ab);
      n_cmp++; if (obs_who !== exp_who || obs_trans !== (exp_held ? 2'd3 : 2'd2)) begin n_err++; $display("FAIL rand_grant_%0d got who=%0d trans=%0d required who=%0d trans=%0d", it, obs_who, obs_trans, exp_who, exp_held ? 3 : 2); end
      n_cmp++; if ({obs_addr, obs_wdata, obs_write, obs_size, obs_prot} !== {exp_addr, exp_wdata, exp_write, exp_size, exp_prot}) begin n_err++; $display("FAIL rand_bus_%0d got addr=%h wdata=%h required addr=%h wdata=%h", it, obs_addr, obs_wdata, exp_addr, exp_wdata); end
      n_cmp++; if (obs_done !== 1'b1 || obs_other_done !== 1'b0 || obs_rdata !== rd || obs_abort !== ab || obs_stable !== 1'b1) begin n_err++; $display("FAIL rand_resp_%0d got done=%b other=%b rdata=%h abort=%b stable=%b required 1/0/%h/%b/1", it, obs_done, obs_other_done, obs_rdata, obs_abort, obs_stable, rd, ab); end
      m_cnt   = exp_held ? ((m_cnt < MAXL) ? m_cnt + 1 : MAXL) : 0;
      m_last  = exp_who;
      m_lock  = exp_who ? l1 : l0;
      m_abort = ab;
    end
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_wait_states();
    test_round_robin();
    test_lock_bound();
    test_abort();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-master arbiter that shares the single memory_controller port between the processor (master 0) and a secondary master (master 1, DMA/debug). It registers the winning master's request onto the memory bus (addr/wdata/write/size/prot/trans), waits for the memory to complete, and returns rdata/abort with a one-cycle done pulse. Arbitration is round-robin, with an optional bounded lock for back-to-back accesses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_LOCK, 4, maximum consecutive locked grants to one master while the other is requesting (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- mN_req  in  1  access request, level (N = 0, 1)
- mN_lock  in  1  request to keep the grant for the next access
- mN_addr / mN_wdata  in  ADDR_W / DATA_W  access address / write data
- mN_write  in  1  1 = write
- mN_size  in  2  0 byte, 1 halfword, 2 word
- mN_prot  in  4  protection attributes, passed through
- mN_gnt  out  1  master owns the bus
- mN_done  out  1  one-cycle completion pulse
- mN_rdata  out  DATA_W  read data; valid with done, held afterwards
- mN_abort  out  1  memory abort; valid with done
- mem_addr, mem_wdata, mem_write, mem_size, mem_prot  out  as above  registered bus to memory_controller
- mem_trans  out  2  0 IDLE, 2 NONSEQ, 3 SEQ
- mem_rdata  in  DATA_W  memory read data
- mem_abort  in  1  memory abort
- mem_ready  in  1  memory completes the current access this cycle

## Operation
- Three-state FSM:
  - IDLE: sample requests.
    - No request → stay in IDLE.
    - Otherwise pick an owner, latch its request fields into the mem_* registers, set gnt, set mem_trans, go to ACCESS.
  - ACCESS: hold all mem_* outputs stable until mem_ready=1 is sampled. At that edge:
    - capture mem_rdata/mem_abort into the owner's rdata/abort
    - set the owner's done
    - set mem_trans=IDLE
    - go to COMPLETE
  - COMPLETE: done=1 and gnt=1 for this cycle only. Requests are ignored. Next state is IDLE.
- Arbitration in IDLE:
  - Only one master requesting → it wins.
  - Both requesting → the master not granted last wins, with two exceptions:
    - Lock hold: the previous owner keeps the grant if it had lock=1 at its last grant, it requests again, its previous access did not abort, and lock_cnt < MAX_LOCK.
    - last_grant resets to 1, so master 0 wins the first tie.
- lock_cnt:
  - increments on each held grant
  - clears whenever ownership changes, or when the previous owner requests without lock
  - when the other master is idle, the hold is unbounded and lock_cnt saturates
- mem_trans:
  - SEQ for a held (locked) grant
  - NONSEQ for every other grant
- Masters must drop req in the cycle they see done, unless another access is intended.
- Reset values:
  - state IDLE, all gnt/done/abort 0, rdata 0
  - mem_trans 0, mem_write 0, mem_addr/mem_wdata/mem_size/mem_prot 0
  - last_grant 1, lock_cnt 0
- Reset asserted mid-ACCESS: the access is dropped silently (no done), and all outputs return to their reset values on the next edge.
- Abort: completes like a normal access. It also forces re-arbitration, with no lock hold, on the next grant.

## Timing
- Requests are sampled only in IDLE. The bus is driven on the cycle after the sampling edge.
- Minimum access is 3 cycles (IDLE, ACCESS with mem_ready=1, COMPLETE). Each mem_ready=0 cycle adds one.
- Latency from req sampled to done high = 2 + (number of mem_ready=0 cycles).
- The maximum completion rate is one access per 3 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- mem_ready outside ACCESS is ignored.
- Same-cycle req from both masters in IDLE resolves per the arbitration rules, deterministically.

## Structure
- Package memory_arbiter_pkg holds:
  - state enum (IDLE, ACCESS, COMPLETE)
  - trans encodings (TRANS_IDLE=2'd0, TRANS_NONSEQ=2'd2, TRANS_SEQ=2'd3)
  - size encodings
- Sub-module arb_pick: a combinational two-way picker taking (req0, req1, last_grant, hold_owner, hold_valid) and returning (valid, winner).
- The FSM, lock counter, and bus registers live in memory_arbiter.

## Test plan
- Single read: m0 reads addr 0x100, mem_ready held high, mem_rdata=0xDEADBEEF.
  - mem_trans=2 one cycle after the req is sampled.
  - m0_done is high two cycles after the req is sampled, with m0_rdata=0xDEADBEEF.
  - mem_trans=0 in the done cycle.
- Wait states: m1 writes 0x55 to 0x200 with mem_ready low for 3 cycles.
  - mem_addr/mem_wdata stay stable for 4 ACCESS cycles.
  - m1_done is high 5 cycles after the req is sampled.
- Contention round-robin: m0 and m1 request continuously without lock.
  - Grants alternate 0,1,0,1.
  - No master receives two consecutive grants.
- Lock bound: m0 holds req and lock=1 while m1 requests, MAX_LOCK=4.
  - m0 gets 5 consecutive grants (1 initial + 4 held), with mem_trans 2,3,3,3,3.
  - m1 is granted next.
- Abort: mem_abort=1 with mem_ready on a locked m0 access while m1 requests.
  - m0_abort=1 with m0_done.
  - The next grant goes to m1.
- Reset mid-ACCESS: assert reset during a wait state.
  - No done pulse is produced.
  - On the next edge all outputs are 0, state is IDLE, and master 0 wins the following tie.
